// File: rtl/sha3_pad_16.sv
// SHA-3 multi-rate padding stage for a 16-bit little-endian word stream.
// Message words pass through unchanged. On the last word of a message the
// domain/pad byte 0x06 goes into the first free byte, the rest of the rate
// block is zero-filled, and 0x80 is set in the final byte of that block.
module sha3_pad_16 #(
  parameter int WIDTH      = 16,
  parameter int RATE_WORDS = 68
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             TLAST,
  input  logic [2:0]       TUSER,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {
    DATA = 2'd0,
    PEND = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       idx;
  logic             blk_end;
  logic [WIDTH-1:0] end_bit;
  logic [WIDTH-1:0] dout_nxt;

  // Valid byte count of the last word; anything above 2 means a full word.
  function automatic logic [1:0] byte_cnt(input logic [2:0] tuser);
    if (tuser >= 3'd2) begin
      return 2'd2;
    end
    return tuser[1:0];
  endfunction

  assign blk_end = (idx == 8'(RATE_WORDS - 1));
  assign end_bit = blk_end ? 16'h8000 : 16'h0000;

  // Next-state and next output word.
  always_comb begin
    state_nxt = state;
    dout_nxt  = din;
    case (state)
      DATA: begin
        if (TLAST) begin
          case (byte_cnt(TUSER))
            2'd0: begin
              dout_nxt  = 16'h0006 | end_bit;
              state_nxt = blk_end ? DATA : FILL;
            end
            2'd1: begin
              dout_nxt  = {8'h06, din[7:0]} | end_bit;
              state_nxt = blk_end ? DATA : FILL;
            end
            default: begin
              // Full last word: the pad byte lands in the next word, which
              // may be the first word of the following block.
              dout_nxt  = din;
              state_nxt = PEND;
            end
          endcase
        end
      end
      PEND: begin
        dout_nxt  = 16'h0006 | end_bit;
        state_nxt = blk_end ? DATA : FILL;
      end
      FILL: begin
        dout_nxt  = 16'h0000 | end_bit;
        state_nxt = blk_end ? DATA : FILL;
      end
      default: begin
        dout_nxt  = 16'h0000;
        state_nxt = DATA;
      end
    endcase
  end

  // Stage 0 -> registered output: state, word index and output word.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= DATA;
      idx   <= 8'd0;
      dout  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= blk_end ? 8'd0 : idx + 8'd1;
      dout  <= dout_nxt;
    end
  end

endmodule

// File: tb/tb_sha3_pad_16.sv
// Testbench for sha3_pad_16 with RATE_WORDS=4: directed scenarios plus
// randomized traffic checked against a byte-level padding model.
module tb_sha3_pad_16;

  localparam int R = 4;

  logic        ACLK;
  logic        ARESET;
  logic        TLAST;
  logic [2:0]  TUSER;
  logic [15:0] din;
  logic [15:0] dout;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_idx = 0;
  logic [15:0] m_q[$];
  logic [15:0] exp_dout;

  sha3_pad_16 #(.WIDTH(16), .RATE_WORDS(R)) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .TLAST (TLAST),
    .TUSER (TUSER),
    .din   (din),
    .dout  (dout)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Byte-oriented model: on a last word, build the padded remainder of the
  // block (spilling into the next block if the pad byte does not fit) and
  // queue its words; queued words take precedence over the input.
  task automatic model_step(input logic rst, input logic tl,
                            input logic [2:0] tu, input logic [15:0] d);
    logic [7:0] bytes[$];
    int n, span;
    if (rst) begin
      m_q.delete();
      m_idx    = 0;
      exp_dout = 16'h0000;
      return;
    end
    if (m_q.size() > 0) begin
      exp_dout = m_q.pop_front();
    end else if (!tl) begin
      exp_dout = d;
    end else begin
      n    = (tu > 3'd2) ? 2 : int'(tu);
      span = (R - m_idx) * 2;
      if (n + 1 > span) span += 2 * R;
      for (int i = 0; i < span; i++) bytes.push_back(8'h00);
      for (int i = 0; i < n; i++) bytes[i] = d[8*i +: 8];
      bytes[n]        = 8'h06;
      bytes[span - 1] = bytes[span - 1] | 8'h80;
      exp_dout = {bytes[1], bytes[0]};
      for (int w = 1; w < span / 2; w++) m_q.push_back({bytes[2*w+1], bytes[2*w]});
    end
    m_idx = (m_idx + 1) % R;
  endtask

  // Apply one word slot, clock it in, update the model; sample 1 ns after the edge.
  task automatic drive(input logic rst, input logic tl, input logic [2:0] tu,
                       input logic [15:0] d);
    ARESET = rst;
    TLAST  = tl;
    TUSER  = tu;
    din    = d;
    @(posedge ACLK);
    model_step(rst, tl, tu, d);
    #1;
  endtask

  // Idle with TLAST=0 until the model is in data mode at the requested index.
  task automatic align_to(input int target);
    int guard = 0;
    while ((m_q.size() != 0 || m_idx != target) && guard < 4 * R) begin
      drive(1'b0, 1'b0, 3'd0, 16'hFFFF);
      guard++;
    end
    total++;
    if (guard >= 4 * R) begin
      bad++;
      $display("FAIL align_to: got guard=%0d want <%0d", guard, 4 * R);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom), 3'($urandom), 16'($urandom));
      total++;
      if (dout !== 16'h0000) begin
        bad++;
        $display("FAIL reset_dout: got %h want 0000", dout);
      end
    end
  endtask

  task automatic test_passthrough;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 3'($urandom), 16'hFFFF);
      total++;
      if (dout !== 16'hFFFF) begin
        bad++;
        $display("FAIL passthrough[%0d]: got %h want FFFF", i, dout);
      end
    end
  endtask

  task automatic test_n1_mid;
    logic [15:0] want[3];
    want[0] = 16'h06FF; want[1] = 16'h0000; want[2] = 16'h8000;
    align_to(1);
    drive(1'b0, 1'b1, 3'd1, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) drive(1'b0, 1'b0, 3'd0, 16'hFFFF);
      total++;
      if (dout !== want[i]) begin
        bad++;
        $display("FAIL n1_mid[%0d]: got %h want %h", i, dout, want[i]);
      end
    end
    drive(1'b0, 1'b0, 3'd0, 16'hA5C3);
    total++;
    if (dout !== 16'hA5C3) begin
      bad++;
      $display("FAIL n1_mid_after: got %h want A5C3", dout);
    end
  endtask

  task automatic test_n0_end;
    align_to(3);
    drive(1'b0, 1'b1, 3'd0, 16'hFFFF);
    total++;
    if (dout !== 16'h8006) begin
      bad++;
      $display("FAIL n0_end: got %h want 8006", dout);
    end
    drive(1'b0, 1'b0, 3'd0, 16'hFFFF);
    total++;
    if (dout !== 16'hFFFF) begin
      bad++;
      $display("FAIL n0_end_next: got %h want FFFF", dout);
    end
  endtask

  task automatic test_n1_end;
    align_to(3);
    drive(1'b0, 1'b1, 3'd1, 16'h12AB);
    total++;
    if (dout !== 16'h86AB) begin
      bad++;
      $display("FAIL n1_end: got %h want 86AB", dout);
    end
  endtask

  task automatic test_n2_end;
    logic [15:0] want[5];
    want[0] = 16'hFFFF; want[1] = 16'h0006; want[2] = 16'h0000;
    want[3] = 16'h0000; want[4] = 16'h8000;
    align_to(3);
    drive(1'b0, 1'b1, 3'd2, 16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) drive(1'b0, 1'b0, 3'd0, 16'hFFFF);
      total++;
      if (dout !== want[i]) begin
        bad++;
        $display("FAIL n2_end[%0d]: got %h want %h", i, dout, want[i]);
      end
    end
  endtask

  task automatic test_tuser_sweep;
    align_to(0);
    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < 5; c++) begin
        drive(1'b0, 1'b1, 3'(t), 16'($urandom));
        total++;
        if (dout !== exp_dout) begin
          bad++;
          $display("FAIL tuser_sweep[t=%0d c=%0d]: got %h want %h", t, c, dout, exp_dout);
        end
      end
    end
  endtask

  task automatic test_reset_mid_fill;
    align_to(0);
    drive(1'b0, 1'b1, 3'd0, 16'hFFFF);
    drive(1'b1, 1'b0, 3'd0, 16'hFFFF);
    total++;
    if (dout !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mid_fill: got %h want 0000", dout);
    end
    drive(1'b0, 1'b0, 3'd0, 16'h1234);
    total++;
    if (dout !== 16'h1234) begin
      bad++;
      $display("FAIL reset_mid_fill_pass: got %h want 1234", dout);
    end
    // Index must restart at 0: a 1-byte last word at the 4th slot after reset ends the block.
    drive(1'b0, 1'b0, 3'd0, 16'h1111);
    drive(1'b0, 1'b0, 3'd0, 16'h2222);
    drive(1'b0, 1'b1, 3'd1, 16'h3344);
    total++;
    if (dout !== 16'h8644) begin
      bad++;
      $display("FAIL reset_mid_fill_idx: got %h want 8644", dout);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            3'($urandom), 16'($urandom));
      total++;
      if (dout !== exp_dout) begin
        bad++;
        $display("FAIL random[%0d]: got %h want %h", i, dout, exp_dout);
      end
    end
  endtask

  initial begin
    ARESET = 1'b1;
    TLAST  = 1'b0;
    TUSER  = 3'd0;
    din    = 16'h0000;
    test_reset();
    test_passthrough();
    test_n1_mid();
    test_n0_end();
    test_n1_end();
    test_n2_end();
    test_tuser_sweep();
    test_reset_mid_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
